// File: rtl/flit_buffer_if.sv
// Bus bundle between a flit_buffer and the logic around it.
// The slave modport is the buffer's view; the master modport is its neighbours' view.
interface flit_buffer_if #(
    parameter int VC_NUM_PER_PORT = 4,
    parameter int PYLD_WIDTH      = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int VC_ID_WIDTH     = VC_NUM_PER_PORT,
    parameter int FLIT_WIDTH      = PYLD_WIDTH + FLIT_TYPE_WIDTH + VC_ID_WIDTH
);
    logic                       in_wr_en;
    logic [FLIT_WIDTH-1:0]      flit_in;
    logic [VC_NUM_PER_PORT-1:0] rd_vc;
    logic                       out_wr_en;
    logic [FLIT_WIDTH-1:0]      flit_out;
    logic [VC_NUM_PER_PORT-1:0] vc_not_empty;
    logic [VC_NUM_PER_PORT-1:0] head_is_hdr;
    logic [VC_NUM_PER_PORT-1:0] credit_out;
    logic [2:0]                 err_flags;

    modport master (
        output in_wr_en, flit_in, rd_vc,
        input  out_wr_en, flit_out, vc_not_empty, head_is_hdr, credit_out, err_flags
    );

    modport slave (
        input  in_wr_en, flit_in, rd_vc,
        output out_wr_en, flit_out, vc_not_empty, head_is_hdr, credit_out, err_flags
    );
endinterface

// File: rtl/flit_buffer.sv
// Router input buffer: one circular FIFO per virtual channel, registered pop output
// with a credit pulse per popped flit, and sticky overflow/underflow/bad-VC flags.
module flit_buffer #(
    parameter int VC_NUM_PER_PORT     = 4,
    parameter int PYLD_WIDTH          = 32,
    parameter int FLIT_TYPE_WIDTH     = 2,
    parameter int VC_ID_WIDTH         = VC_NUM_PER_PORT,
    parameter int FLIT_WIDTH          = PYLD_WIDTH + FLIT_TYPE_WIDTH + VC_ID_WIDTH,
    parameter int BUFFER_DEPTH_PER_VC = 4
) (
    input logic           clk,
    input logic           reset,
    flit_buffer_if.slave  bus
);
    localparam int               PTR_W    = $clog2(BUFFER_DEPTH_PER_VC);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH_PER_VC);

    logic [FLIT_WIDTH-1:0]      mem_q    [VC_NUM_PER_PORT][BUFFER_DEPTH_PER_VC];
    logic [FLIT_WIDTH-1:0]      mem_d    [VC_NUM_PER_PORT][BUFFER_DEPTH_PER_VC];
    logic [PTR_W-1:0]           wr_ptr_q [VC_NUM_PER_PORT];
    logic [PTR_W-1:0]           wr_ptr_d [VC_NUM_PER_PORT];
    logic [PTR_W-1:0]           rd_ptr_q [VC_NUM_PER_PORT];
    logic [PTR_W-1:0]           rd_ptr_d [VC_NUM_PER_PORT];
    logic [CNT_W-1:0]           cnt_q    [VC_NUM_PER_PORT];
    logic [CNT_W-1:0]           cnt_d    [VC_NUM_PER_PORT];
    logic                       out_wr_en_q, out_wr_en_d;
    logic [FLIT_WIDTH-1:0]      flit_out_q, flit_out_d;
    logic [VC_NUM_PER_PORT-1:0] credit_q, credit_d;
    logic [2:0]                 err_q, err_d;

    logic [VC_ID_WIDTH-1:0]     wr_vc;
    logic                       wr_vc_ok;
    logic                       rd_ok;
    logic [VC_NUM_PER_PORT-1:0] push_req;
    logic [VC_NUM_PER_PORT-1:0] push;
    logic [VC_NUM_PER_PORT-1:0] pop;
    logic                       overflow;
    logic                       underflow;
    logic                       bad_vc;
    logic [FLIT_WIDTH-1:0]      pop_flit;
    logic [VC_NUM_PER_PORT-1:0] not_empty;
    logic [VC_NUM_PER_PORT-1:0] front_hdr;

    assign wr_vc    = bus.flit_in[PYLD_WIDTH +: VC_ID_WIDTH];
    assign wr_vc_ok = $onehot(wr_vc);
    assign rd_ok    = $onehot(bus.rd_vc);

    // A full VC still takes a write when the same VC is popped this cycle.
    always_comb begin
        pop      = '0;
        push_req = '0;
        push     = '0;
        for (int i = 0; i < VC_NUM_PER_PORT; i++) begin
            pop[i]      = rd_ok && bus.rd_vc[i] && (cnt_q[i] != '0);
            push_req[i] = bus.in_wr_en && wr_vc_ok && wr_vc[i];
            push[i]     = push_req[i] && ((cnt_q[i] != FULL_CNT) || pop[i]);
        end
        overflow  = |(push_req & ~push);
        underflow = (bus.rd_vc != '0) && (pop == '0);
        bad_vc    = bus.in_wr_en && !wr_vc_ok;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        pop_flit = '0;
        for (int i = 0; i < VC_NUM_PER_PORT; i++) begin
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = bus.flit_in;
                wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                pop_flit    = mem_q[i][rd_ptr_q[i]];
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            end
            case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        out_wr_en_d = |pop;
        flit_out_d  = (|pop) ? pop_flit : flit_out_q;
        credit_d    = pop;
        err_d       = err_q | {bad_vc, underflow, overflow};
    end

    // Flit storage is never reset; validity comes only from the counters.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '{default: '0};
            rd_ptr_q    <= '{default: '0};
            cnt_q       <= '{default: '0};
            out_wr_en_q <= 1'b0;
            flit_out_q  <= '0;
            credit_q    <= '0;
            err_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_wr_en_q <= out_wr_en_d;
            flit_out_q  <= flit_out_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
        end
    end

    // Types head (10) and single (11) are exactly those with the type MSB set.
    always_comb begin
        not_empty = '0;
        front_hdr = '0;
        for (int i = 0; i < VC_NUM_PER_PORT; i++) begin
            not_empty[i] = (cnt_q[i] != '0);
            front_hdr[i] = not_empty[i] && mem_q[i][rd_ptr_q[i]][FLIT_WIDTH-1];
        end
    end

    assign bus.out_wr_en    = out_wr_en_q;
    assign bus.flit_out     = flit_out_q;
    assign bus.credit_out   = credit_q;
    assign bus.err_flags    = err_q;
    assign bus.vc_not_empty = not_empty;
    assign bus.head_is_hdr  = front_hdr;
endmodule

// File: tb/tb_flit_buffer.sv
// Scoreboard bench for flit_buffer: the driver updates a queue-per-VC model and
// queues expected pops; a separate monitor compares every cycle's outputs.
module tb_flit_buffer;
    localparam int VC    = 4;
    localparam int DEPTH = 4;
    localparam int FW    = 38;

    logic clk;
    logic reset;
    bit   mon_en;
    int   total_checks;
    int   passed_checks;

    logic [FW-1:0]   model_q [VC][$];
    logic [FW+VC-1:0] exp_q [$];
    logic [2:0]      model_err;
    logic [FW-1:0]   last_flit;

    flit_buffer_if bus ();

    flit_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check_output(string name, logic [63:0] act, logic [63:0] exp);
        total_checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            passed_checks++;
    endfunction

    function automatic logic [FW-1:0] mk_flit(logic [1:0] ftype, logic [3:0] vc, logic [31:0] pyld);
        return {ftype, vc, pyld};
    endfunction

    function automatic int onehot_index(logic [3:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < VC; i++)
            if (v[i]) idx = i;
        return idx;
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < VC; i++) model_q[i].delete();
        exp_q.delete();
        model_err = '0;
        last_flit = '0;
    endfunction

    // One cycle of stimulus; the model applies the buffer's rules at queue level.
    task automatic apply_stimulus(input logic wr, input logic [FW-1:0] flit, input logic [3:0] rd);
        logic [3:0]    vcf;
        logic [FW-1:0] f;
        int            pop_vc;
        int            push_vc;
        int            idx;
        @(negedge clk);
        bus.in_wr_en = wr;
        bus.flit_in  = flit;
        bus.rd_vc    = rd;
        vcf     = flit[35:32];
        pop_vc  = -1;
        push_vc = -1;
        if (rd != 4'b0) begin
            if ($onehot(rd)) begin
                idx = onehot_index(rd);
                if (model_q[idx].size() > 0) pop_vc = idx;
                else model_err[1] = 1'b1;
            end else begin
                model_err[1] = 1'b1;
            end
        end
        if (wr) begin
            if ($onehot(vcf)) begin
                idx = onehot_index(vcf);
                if (model_q[idx].size() < DEPTH || pop_vc == idx) push_vc = idx;
                else model_err[0] = 1'b1;
            end else begin
                model_err[2] = 1'b1;
            end
        end
        if (pop_vc >= 0) begin
            f = model_q[pop_vc].pop_front();
            exp_q.push_back({4'(1 << pop_vc), f});
        end
        if (push_vc >= 0) model_q[push_vc].push_back(flit);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 4'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_wr_en = 1'b0;
        bus.flit_in  = '0;
        bus.rd_vc    = '0;
        reset        = 1'b0;
        clear_model();
        #2;
        check_output("reset_outputs",
                     64'({bus.out_wr_en, bus.flit_out, bus.credit_out, bus.err_flags,
                          bus.vc_not_empty, bus.head_is_hdr}), 64'd0);
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: samples just after each rising edge, when the model matches the DUT.
    initial begin
        logic [FW+VC-1:0] e;
        logic [VC-1:0]    exp_ne;
        logic [VC-1:0]    exp_hd;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                check_output("out_wr_en", 64'(bus.out_wr_en), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_output("flit_out", 64'(bus.flit_out), 64'(e[FW-1:0]));
                    check_output("credit_out", 64'(bus.credit_out), 64'(e[FW+VC-1:FW]));
                    last_flit = e[FW-1:0];
                end else begin
                    check_output("credit_idle", 64'(bus.credit_out), 64'd0);
                    check_output("flit_hold", 64'(bus.flit_out), 64'(last_flit));
                end
                exp_ne = '0;
                exp_hd = '0;
                for (int i = 0; i < VC; i++) begin
                    if (model_q[i].size() > 0) begin
                        exp_ne[i] = 1'b1;
                        exp_hd[i] = model_q[i][0][FW-1];
                    end
                end
                check_output("status", 64'({bus.err_flags, bus.vc_not_empty, bus.head_is_hdr}),
                             64'({model_err, exp_ne, exp_hd}));
            end
        end
    end

    initial begin
        logic [3:0]  rd;
        logic [3:0]  vcf;
        logic        wr;
        int          r;
        total_checks  = 0;
        passed_checks = 0;
        mon_en        = 1'b0;
        reset         = 1'b1;
        bus.in_wr_en  = 1'b0;
        bus.flit_in   = '0;
        bus.rd_vc     = '0;
        clear_model();

        // Head flit becomes visible one cycle after the write.
        do_reset();
        apply_stimulus(1'b1, mk_flit(2'b10, 4'b0010, 32'hA5A5_0001), 4'b0);
        settle();
        check_output("t035_not_empty", 64'(bus.vc_not_empty), 64'h2);
        check_output("t035_head", 64'(bus.head_is_hdr), 64'h2);
        idle_cycles(1);

        // Overflow on VC0, then in-order drain.
        do_reset();
        for (int i = 1; i <= 5; i++) apply_stimulus(1'b1, mk_flit(2'b00, 4'b0001, 32'(i)), 4'b0);
        settle();
        check_output("t036_err", 64'(bus.err_flags), 64'h1);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, 4'b0001);
        idle_cycles(2);

        // Full VC3 accepts a write alongside a pop.
        do_reset();
        for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, mk_flit(2'b00, 4'b1000, 32'(i)), 4'b0);
        apply_stimulus(1'b1, mk_flit(2'b01, 4'b1000, 32'd9), 4'b1000);
        settle();
        check_output("t037_err", 64'(bus.err_flags), 64'h0);
        check_output("t037_not_empty", 64'(bus.vc_not_empty), 64'h8);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, 4'b1000);
        idle_cycles(2);

        // No write-to-read bypass on an empty VC.
        do_reset();
        apply_stimulus(1'b1, mk_flit(2'b11, 4'b0100, 32'h77), 4'b0100);
        settle();
        check_output("t038_out_wr_en", 64'(bus.out_wr_en), 64'h0);
        check_output("t038_err", 64'(bus.err_flags), 64'h2);
        check_output("t038_not_empty", 64'(bus.vc_not_empty), 64'h4);

        // Bad VC field is dropped; later good writes still land.
        do_reset();
        apply_stimulus(1'b1, mk_flit(2'b10, 4'b0011, 32'h55), 4'b0);
        settle();
        check_output("t039_err", 64'(bus.err_flags), 64'h4);
        apply_stimulus(1'b1, mk_flit(2'b10, 4'b0001, 32'h56), 4'b0);
        settle();
        check_output("t039_not_empty", 64'(bus.vc_not_empty), 64'h1);

        // Reset mid-stream discards VC1 contents without credits.
        do_reset();
        for (int i = 1; i <= 3; i++) apply_stimulus(1'b1, mk_flit(2'b00, 4'b0010, 32'(i)), 4'b0);
        do_reset();
        idle_cycles(3);
        check_output("t040_not_empty", 64'(bus.vc_not_empty), 64'h0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            wr = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 9) == 0) vcf = 4'($urandom);
            else vcf = 4'(1 << $urandom_range(0, 3));
            r = $urandom_range(0, 99);
            if (r < 45) rd = 4'b0;
            else if (r < 95) rd = 4'(1 << $urandom_range(0, 3));
            else rd = 4'($urandom);
            apply_stimulus(wr, mk_flit(2'($urandom), vcf, $urandom), rd);
            if (n == 400) do_reset();
        end
        idle_cycles(3);

        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule

// File: doc/flit_buffer.md
FLIT_BUFFER -- requirements
Module: flit_buffer

Interface
REQ-001 Parameter VC_NUM_PER_PORT, default 4: number of virtual channels (VCs) per input port.
REQ-002 Parameter PYLD_WIDTH, default 32: flit payload width.
REQ-003 Parameter FLIT_TYPE_WIDTH, default 2: flit type field width.
REQ-004 Parameter VC_ID_WIDTH, default VC_NUM_PER_PORT: width of the one-hot VC field.
REQ-005 Parameter FLIT_WIDTH, default PYLD_WIDTH+FLIT_TYPE_WIDTH+VC_ID_WIDTH: total flit width.
REQ-006 Parameter BUFFER_DEPTH_PER_VC, default 4, power of two, 2 or more: flit slots per VC.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-009 in_wr_en  input  1  flit_in valid this cycle (from the upstream router output switch).
REQ-010 flit_in  input  FLIT_WIDTH  layout: [FLIT_WIDTH-1 -: 2] type, [PYLD_WIDTH +: VC_ID_WIDTH] one-hot VC, [PYLD_WIDTH-1:0] payload.
REQ-011 rd_vc  input  VC_NUM_PER_PORT  one-hot read request; all zero means idle.
REQ-012 out_wr_en  output  1  flit_out valid (registered).
REQ-013 flit_out  output  FLIT_WIDTH  flit popped in the previous cycle (registered).
REQ-014 vc_not_empty  output  VC_NUM_PER_PORT  bit i = VC i holds at least one flit.
REQ-015 head_is_hdr  output  VC_NUM_PER_PORT  bit i = front flit of VC i has type head (2'b10) or single (2'b11).
REQ-016 credit_out  output  VC_NUM_PER_PORT  one-cycle pulse per accepted pop, returned upstream (registered).
REQ-017 err_flags  output  3  sticky: [0] overflow, [1] underflow, [2] bad VC field.

Function
REQ-018 Flit type encoding: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single-flit; the buffer stores all types unchanged.
REQ-019 Each VC is an independent circular FIFO with a write pointer and a read pointer, each log2(BUFFER_DEPTH_PER_VC) bits, and an occupancy counter of log2(BUFFER_DEPTH_PER_VC)+1 bits.
REQ-020 Write: when in_wr_en=1 and the VC field is exactly one-hot, the flit goes to the addressed VC, its write pointer increments modulo depth, and its count increments.
REQ-021 If in_wr_en=1 and the VC field is zero or has more than one bit set, the flit is dropped and err_flags[2] is set.
REQ-022 If in_wr_en=1 and the addressed VC is full (count = depth) with no pop of that VC this cycle, the flit is dropped, err_flags[0] is set, and the VC state is unchanged.
REQ-023 If the addressed VC is full and a pop of that VC is accepted in the same cycle, the write is accepted and the count stays at depth.
REQ-024 Read: when rd_vc has exactly one bit i set and VC i is non-empty, the front flit is popped, the read pointer increments modulo depth, and the count decrements.
REQ-025 On the cycle after an accepted pop: out_wr_en=1, flit_out = the popped flit, and credit_out[i]=1; otherwise out_wr_en=0, credit_out=0, and flit_out holds its last value.
REQ-026 A pop request on an empty VC is ignored and sets err_flags[1]; there is no write-to-read bypass, so a simultaneous write to an empty VC does not make the pop valid.
REQ-027 If rd_vc is not one-hot and not zero, no pop occurs and err_flags[1] is set.
REQ-028 A simultaneous write and pop on the same non-empty VC leave its count unchanged; write and pop on different VCs update independently.
REQ-029 vc_not_empty and head_is_hdr are combinational functions of the current registered state (counts and front entries); they do not depend on this cycle's inputs.
REQ-030 Pop latency is 1 cycle. Write-to-visible latency is 1 cycle: vc_not_empty rises on the cycle after the write.
REQ-031 Once set, err_flags bits are cleared only by reset.

Reset
REQ-032 While reset=0: all pointers and counts = 0, out_wr_en=0, flit_out=0, credit_out=0, err_flags=0, and therefore vc_not_empty=0 and head_is_hdr=0.
REQ-033 Reset asserted mid-packet discards all stored flits immediately and asynchronously, with no credit pulses.
REQ-034 Storage array contents need not be reset; only the control state defined in REQ-032 must be reset.

Verification
REQ-035 Reset release, then write head flit type=2'b10, vc=4'b0010, payload=32'hA5A5_0001 -> next cycle vc_not_empty=4'b0010 and head_is_hdr=4'b0010.
REQ-036 Write 4 flits to VC0 (payloads 1..4), then a 5th with no pop -> 5th dropped and err_flags=3'b001; 4 pops then yield payloads 1,2,3,4 in order, each with credit_out=4'b0001 one cycle after its pop.
REQ-037 VC3 full, same-cycle write payload 9 and rd_vc=4'b1000 -> write accepted, count stays 4, no error; payload 9 emerges on the 4th following pop.
REQ-038 Empty VC2, same-cycle write and rd_vc=4'b0100 -> no out_wr_en, err_flags[1]=1, vc_not_empty[2]=1 the next cycle.
REQ-039 Write with vc=4'b0011 -> dropped and err_flags[2]=1; a later write with vc=4'b0001 is still accepted.
REQ-040 Fill VC1 with 3 flits, drive reset low for one cycle mid-stream -> all outputs 0 while reset is low; after release vc_not_empty=0 and no credit_out pulses occur.
